// File: rtl/lsu_mem_pkg.sv
// lsu_mem_pkg: shared widths, FSM states and request record for the LSU memory arbiter
package lsu_mem_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int MASK_W = DATA_W / 8;
  localparam int PID_W = 2;
  localparam logic [2:0] WS_DONE = 3'b100;
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} arb_state_e;
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
    logic [PID_W-1:0]  pID;
  } mem_req_t;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: 2-way oldest-first picker; a way left waiting last cycle beats a fresh one, ties go to way0
module mem_arb_pick (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       clr,
  input  logic [1:0] valid,
  output logic [1:0] grant
);
  logic [1:0] waiting, old;
  always_comb begin
    old = valid & waiting;
    grant = !en     ? 2'b00 :
            old[0]   ? 2'b01 :
            old[1]   ? 2'b10 :
            valid[0] ? 2'b01 :
            valid[1] ? 2'b10 : 2'b00;
  end
  always_ff @(posedge clk)
    if (!reset_n || clr) waiting <= 2'b00;
    else waiting <= valid & ~grant;
endmodule

// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter: shares the data-RAM port between the way0/way1 memory stages,
// one access at a time, responses tagged with the requester's pID
module lsu_mem_arbiter
  import lsu_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush_i,
  input  logic              way0_req_valid_i,
  output logic              way0_req_ready_o,
  input  logic              way0_req_we_i,
  input  logic [ADDR_W-1:0] way0_req_addr_i,
  input  logic [DATA_W-1:0] way0_req_wdata_i,
  input  logic [MASK_W-1:0] way0_req_wmask_i,
  input  logic [PID_W-1:0]  way0_req_pID_i,
  output logic              way0_resp_valid_o,
  output logic [DATA_W-1:0] way0_resp_rdata_o,
  output logic [PID_W-1:0]  way0_resp_pID_o,
  input  logic              way1_req_valid_i,
  output logic              way1_req_ready_o,
  input  logic              way1_req_we_i,
  input  logic [ADDR_W-1:0] way1_req_addr_i,
  input  logic [DATA_W-1:0] way1_req_wdata_i,
  input  logic [MASK_W-1:0] way1_req_wmask_i,
  input  logic [PID_W-1:0]  way1_req_pID_i,
  output logic              way1_resp_valid_o,
  output logic [DATA_W-1:0] way1_resp_rdata_o,
  output logic [PID_W-1:0]  way1_resp_pID_o,
  output logic              ram_read_en_o,
  output logic [ADDR_W-1:0] ram_read_addr_o,
  output logic              ram_write_en_o,
  output logic [ADDR_W-1:0] ram_write_addr_o,
  output logic [DATA_W-1:0] ram_write_data_o,
  output logic [MASK_W-1:0] ram_write_mask_o,
  input  logic [DATA_W-1:0] ram_read_data_i,
  input  logic              ram_data_ok_i,
  input  logic [2:0]        ram_write_state_i
);
  arb_state_e state, state_next;
  mem_req_t req, req_in;
  logic [1:0] grant;
  logic idle, owner, drop, resp;
  logic [DATA_W-1:0] rdata;
  assign idle = state == IDLE;
  mem_arb_pick u_pick (
    .clk,
    .reset_n,
    .en   (reset_n && idle && !flush_i),
    .clr  (idle && flush_i),
    .valid({way1_req_valid_i, way0_req_valid_i}),
    .grant
  );
  always_comb
    req_in = grant[1] ?
      {way1_req_we_i, way1_req_addr_i, way1_req_wdata_i, way1_req_wmask_i, way1_req_pID_i} :
      {way0_req_we_i, way0_req_addr_i, way0_req_wdata_i, way0_req_wmask_i, way0_req_pID_i};
  always_ff @(posedge clk)
    if (!reset_n) state <= IDLE;
    else state <= state_next;
  always_comb
    state_next = state == IDLE    ? (|grant ? (req_in.we ? WR_WAIT : RD_WAIT) : IDLE) :
                 state == RD_WAIT ? (ram_data_ok_i ? RESP : RD_WAIT) :
                 state == WR_WAIT ? (ram_write_state_i == WS_DONE ? RESP : WR_WAIT) : IDLE;
  // a flush while the RAM is busy lets the access finish but remembers to swallow its response
  always_ff @(posedge clk)
    if (!reset_n) begin
      req   <= '0;
      owner <= 1'b0;
      drop  <= 1'b0;
      rdata <= '0;
    end else begin
      if (|grant) begin
        req   <= req_in;
        owner <= grant[1];
        drop  <= 1'b0;
      end
      if ((state == RD_WAIT || state == WR_WAIT) && flush_i) drop <= 1'b1;
      if (state == RD_WAIT && ram_data_ok_i) rdata <= ram_read_data_i;
    end
  always_comb begin
    resp              = state == RESP && !drop && !flush_i;
    way0_req_ready_o  = grant[0];
    way1_req_ready_o  = grant[1];
    way0_resp_valid_o = resp && !owner;
    way1_resp_valid_o = resp && owner;
    way0_resp_rdata_o = req.we ? '0 : rdata;
    way1_resp_rdata_o = req.we ? '0 : rdata;
    way0_resp_pID_o   = req.pID;
    way1_resp_pID_o   = req.pID;
    ram_read_en_o     = state == RD_WAIT;
    ram_read_addr_o   = req.addr;
    ram_write_en_o    = state == WR_WAIT;
    ram_write_addr_o  = req.addr;
    ram_write_data_o  = req.wdata;
    ram_write_mask_o  = req.wmask;
  end
endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// tb_lsu_mem_arbiter: directed scenarios then randomized traffic, checked every cycle against a
// timestamp model (request ages, handshake cycle + RAM latency -> enable window, response cycle)
module tb_lsu_mem_arbiter;
  import lsu_mem_pkg::*;
  logic clk = 1'b0;
  logic reset_n = 1'b0, flush = 1'b0;
  logic rv [2], rwe [2], rdy [2], sv [2];
  logic [ADDR_W-1:0] ra [2];
  logic [DATA_W-1:0] rd [2], srd [2];
  logic [MASK_W-1:0] rm [2];
  logic [PID_W-1:0] rp [2], sp [2];
  logic ren, wen, dok;
  logic [ADDR_W-1:0] raddr, waddr;
  logic [DATA_W-1:0] wdata, rram;
  logic [MASK_W-1:0] wmask;
  logic [2:0] ws;
  int checks = 0, errors = 0;
  int k = 0, free_at = 0, hs = -10, done_c = -10, resp_c = -10, lat_cfg = 1;
  int since [2];
  logic m_we = 1'b0, m_own = 1'b0, m_drop = 1'b0, stale = 1'b0, fix_en = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_wdata = '0, m_rdata = '0;
  logic [MASK_W-1:0] m_mask = '0;
  logic [PID_W-1:0] m_pid = '0;
  logic [DATA_W-1:0] fix_rd = 64'hDEADBEEF_12345678;
  int resp_cnt [2];
  int ren_cnt = 0, wen_cnt = 0;
  logic [DATA_W-1:0] last_rd [2];
  logic [PID_W-1:0] last_pid [2];
  int hsq [$];

  always #5 clk = ~clk;

  lsu_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n), .flush_i(flush),
    .way0_req_valid_i(rv[0]), .way0_req_ready_o(rdy[0]), .way0_req_we_i(rwe[0]),
    .way0_req_addr_i(ra[0]), .way0_req_wdata_i(rd[0]), .way0_req_wmask_i(rm[0]),
    .way0_req_pID_i(rp[0]), .way0_resp_valid_o(sv[0]), .way0_resp_rdata_o(srd[0]),
    .way0_resp_pID_o(sp[0]),
    .way1_req_valid_i(rv[1]), .way1_req_ready_o(rdy[1]), .way1_req_we_i(rwe[1]),
    .way1_req_addr_i(ra[1]), .way1_req_wdata_i(rd[1]), .way1_req_wmask_i(rm[1]),
    .way1_req_pID_i(rp[1]), .way1_resp_valid_o(sv[1]), .way1_resp_rdata_o(srd[1]),
    .way1_resp_pID_o(sp[1]),
    .ram_read_en_o(ren), .ram_read_addr_o(raddr), .ram_write_en_o(wen),
    .ram_write_addr_o(waddr), .ram_write_data_o(wdata), .ram_write_mask_o(wmask),
    .ram_read_data_i(rram), .ram_data_ok_i(dok), .ram_write_state_i(ws)
  );

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic req(int i, logic we, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d,
                     logic [MASK_W-1:0] m, logic [PID_W-1:0] p);
    if (!rv[i]) since[i] = k;
    rv[i] = 1'b1; rwe[i] = we; ra[i] = a; rd[i] = d; rm[i] = m; rp[i] = p;
  endtask

  // one clock cycle: drive RAM side, predict, check at the falling edge, advance the model
  task automatic cycle();
    int g;
    logic win, old0, old1, pulse;
    win = k > hs && k <= done_c;
    rram = fix_en ? fix_rd : {$urandom, $urandom};
    dok = (win && !m_we) ? (k == done_c) : (stale ? 1'b1 : 1'($urandom));
    ws = (win && m_we) ? (k == done_c ? WS_DONE : 3'($urandom_range(0, 3))) :
         (stale ? WS_DONE : 3'($urandom));
    if (win && !m_we && k == done_c) m_rdata = rram;
    old0 = rv[0] && since[0] < k;
    old1 = rv[1] && since[1] < k;
    g = (!reset_n || flush || k < free_at) ? -1 :
        old0 ? 0 : old1 ? 1 : rv[0] ? 0 : rv[1] ? 1 : -1;
    pulse = reset_n && k == resp_c && !m_drop && !flush;
    #4;
    chk("ready0", rdy[0], g == 0);
    chk("ready1", rdy[1], g == 1);
    if (reset_n) begin
      chk("read_en", ren, win && !m_we);
      chk("write_en", wen, win && m_we);
      if (win && !m_we) chk("read_addr", raddr, m_addr);
      if (win && m_we) begin
        chk("write_addr", waddr, m_addr);
        chk("write_data", wdata, m_wdata);
        chk("write_mask", wmask, m_mask);
      end
      chk("resp_valid0", sv[0], pulse && !m_own);
      chk("resp_valid1", sv[1], pulse && m_own);
      if (pulse) begin
        chk("resp_pid", sp[m_own], m_pid);
        chk("resp_rdata", srd[m_own], m_we ? 64'd0 : m_rdata);
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (rv[i] && rdy[i] === 1'b1) hsq.push_back(i);
      if (sv[i] === 1'b1) begin
        resp_cnt[i]++;
        last_rd[i] = srd[i];
        last_pid[i] = sp[i];
      end
    end
    if (ren === 1'b1) ren_cnt++;
    if (wen === 1'b1) wen_cnt++;
    if (!reset_n) begin
      free_at = k + 1; hs = -10; done_c = -10; resp_c = -10;
      since = '{k + 1, k + 1};
    end else begin
      if (flush && win) m_drop = 1'b1;
      if (flush && k >= free_at) since = '{k + 1, k + 1};
      if (g >= 0) begin
        m_we = rwe[g]; m_addr = ra[g]; m_wdata = rd[g]; m_mask = rm[g]; m_pid = rp[g];
        m_own = g == 1; m_drop = 1'b0;
        hs = k; done_c = k + lat_cfg; resp_c = done_c + 1; free_at = resp_c + 1;
      end
    end
    @(posedge clk);
    #1;
    if (g >= 0) rv[g] = 1'b0;
    k++;
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  task automatic settle();
    while (k < free_at) cycle();
  endtask

  task automatic clear_obs();
    resp_cnt = '{0, 0}; ren_cnt = 0; wen_cnt = 0; hsq.delete();
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_ren"}, ren, 0);
    chk({tag, "_wen"}, wen, 0);
    chk({tag, "_raddr"}, raddr, 0);
    chk({tag, "_waddr"}, waddr, 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_wmask"}, wmask, 0);
    chk({tag, "_rv0"}, sv[0], 0);
    chk({tag, "_rv1"}, sv[1], 0);
    chk({tag, "_rdata"}, srd[0], 0);
    chk({tag, "_pid"}, sp[1], 0);
  endtask

  initial begin
    rv = '{1'b0, 1'b0}; rwe = '{1'b0, 1'b0}; ra = '{'0, '0}; rd = '{'0, '0};
    rm = '{'0, '0}; rp = '{'0, '0}; since = '{0, 0};
    resp_cnt = '{0, 0}; last_rd = '{'0, '0}; last_pid = '{'0, '0};
    rram = '0; dok = 1'b0; ws = '0;
    @(posedge clk);
    #1;
    run(2);
    reset_n = 1'b1;
    chk_zero("reset");
    run(2);
    // way0 load, 3-cycle RAM, fixed data
    settle(); clear_obs(); lat_cfg = 3; fix_en = 1'b1;
    req(0, 1'b0, 32'h8000_0010, '0, '0, 2'd2);
    run(7);
    fix_en = 1'b0;
    chk("a_resp0", resp_cnt[0], 1);
    chk("a_resp1", resp_cnt[1], 0);
    chk("a_rdata", last_rd[0], 64'hDEADBEEF_12345678);
    chk("a_pid", last_pid[0], 2);
    chk("a_ren", ren_cnt, 3);
    // both valid together: way0 first
    settle(); clear_obs(); lat_cfg = 2;
    req(0, 1'b0, 32'h0000_1000, '0, '0, 2'd1);
    req(1, 1'b1, 32'h0000_2000, 64'h1111_2222_3333_4444, 8'hFF, 2'd3);
    run(12);
    chk("b_n", hsq.size(), 2);
    chk("b_first", hsq[0], 0);
    chk("b_second", hsq[1], 1);
    chk("b_resp", resp_cnt[0] + resp_cnt[1], 2);
    // way1 waiting beats a newly valid way0
    settle(); clear_obs(); lat_cfg = 2;
    req(0, 1'b0, 32'h0000_3000, '0, '0, 2'd0);
    cycle();
    req(1, 1'b1, 32'h0000_4000, 64'h55, 8'h01, 2'd1);
    settle();
    req(0, 1'b0, 32'h0000_5000, '0, '0, 2'd2);
    run(12);
    chk("c_n", hsq.size(), 3);
    chk("c_first", hsq[0], 0);
    chk("c_second", hsq[1], 1);
    chk("c_third", hsq[2], 0);
    // way1 store, mask 0F, 5-cycle write
    settle(); clear_obs(); lat_cfg = 5;
    req(1, 1'b1, 32'h0000_6004, 64'hCAFE_F00D_0BAD_BEEF, 8'h0F, 2'd1);
    run(9);
    chk("d_wen", wen_cnt, 5);
    chk("d_resp1", resp_cnt[1], 1);
    chk("d_rdata", last_rd[1], 0);
    chk("d_pid", last_pid[1], 1);
    // flush during RD_WAIT: read completes, response swallowed
    settle(); clear_obs(); lat_cfg = 4;
    req(0, 1'b0, 32'h0000_7000, '0, '0, 2'd3);
    cycle();
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    run(6);
    chk("e_ren", ren_cnt, 4);
    chk("e_resp", resp_cnt[0] + resp_cnt[1], 0);
    lat_cfg = 1;
    req(1, 1'b0, 32'h0000_7008, '0, '0, 2'd2);
    run(5);
    chk("e_after", resp_cnt[1], 1);
    // reset in WR_WAIT, stale completion afterwards ignored
    settle(); clear_obs(); lat_cfg = 6;
    req(1, 1'b1, 32'h0000_8000, 64'h77, 8'hFF, 2'd3);
    cycle();
    cycle();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    chk_zero("wr_reset");
    clear_obs(); stale = 1'b1;
    run(4);
    stale = 1'b0;
    chk("f_wen", wen_cnt, 0);
    chk("f_resp", resp_cnt[0] + resp_cnt[1], 0);
    // randomized traffic with occasional flush
    repeat (600) begin
      lat_cfg = $urandom_range(1, 4);
      flush = $urandom_range(0, 15) == 0;
      for (int i = 0; i < 2; i++)
        if (!rv[i] && $urandom_range(0, 1) == 1)
          req(i, 1'($urandom), $urandom, {$urandom, $urandom}, 8'($urandom), 2'($urandom));
      cycle();
    end
    flush = 1'b0;
    run(20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
